// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_pkg;

  // Fetch FSM: issue request, wait for read data, hold a valid instruction
  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2
  } fetch_state_e;

  // addi x0,x0,0 shown to decode while no instruction is held
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Sequential fetch step, one 32-bit word
  localparam logic [31:0] PC_INCR = 32'd4;

endpackage

// File: rtl/fetch_pc_gen.sv
// rtl/fetch_pc_gen.sv - next fetch PC select and redirect alignment check
module fetch_pc_gen (
  input  logic [31:0] pc_q,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        advance,
  output logic [31:0] pc_next,
  output logic        misalign
);
  import fetch_pkg::*;

  // Redirect wins over sequential advance; targets are forced word aligned
  always_comb begin
    pc_next = pc_q;
    if (redirect_i) begin
      pc_next = redirect_pc_i & ~32'h3;
    end else if (advance) begin
      pc_next = pc_q + PC_INCR;
    end
  end

  assign misalign = redirect_i & (|redirect_pc_i[1:0]);

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch stage: PC, imem handshake, held instruction
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        misalign_o
);
  import fetch_pkg::*;

  fetch_state_e state_q, state_d;
  logic         kill_q, kill_d;
  logic         capture;
  logic         advance;
  logic         misalign;
  logic         misalign_q;
  logic [31:0]  pc_q, pc_next;
  logic [31:0]  instr_q, pc_out_q;

  assign advance = (state_q == S_VALID) && instr_ready_i;

  fetch_pc_gen u_pc_gen (
    .pc_q          (pc_q),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .advance       (advance),
    .pc_next       (pc_next),
    .misalign      (misalign)
  );

  // Next-state logic; a redirect marks any in-flight response as stale
  always_comb begin
    state_d = state_q;
    kill_d  = kill_q;
    capture = 1'b0;
    case (state_q)
      S_REQ: begin
        if (imem_gnt_i) begin
          state_d = S_WAIT;
          if (redirect_i) kill_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (imem_rvalid_i) begin
          kill_d = 1'b0;
          if (kill_q || redirect_i) begin
            state_d = S_REQ;
          end else begin
            state_d = S_VALID;
            capture = 1'b1;
          end
        end else if (redirect_i) begin
          kill_d = 1'b1;
        end
      end
      S_VALID: begin
        if (redirect_i || instr_ready_i) state_d = S_REQ;
      end
      default: begin
        state_d = S_REQ;
        kill_d  = 1'b0;
      end
    endcase
  end

  // FSM, fetch PC and kill flag registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_REQ;
      kill_q  <= 1'b0;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      pc_q    <= pc_next;
    end
  end

  // Hold the fetched word and its address until decode consumes it
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      instr_q  <= NOP_INSTR;
      pc_out_q <= RESET_PC;
    end else if (capture) begin
      instr_q  <= imem_rdata_i;
      pc_out_q <= pc_q;
    end
  end

  // One-cycle pulse flagging a misaligned redirect target
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign;
    end
  end

  assign imem_req_o    = (state_q == S_REQ) && !rst_i;
  assign imem_addr_o   = pc_q;
  assign instr_valid_o = (state_q == S_VALID);
  assign instr_o       = (state_q == S_VALID) ? instr_q : NOP_INSTR;
  assign pc_o          = pc_out_q;
  assign misalign_o    = misalign_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch
module tb_instr_fetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        gnt = 1'b0;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = 32'h0;
  logic        valid;
  logic        ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] pc_out;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        misalign;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_pc;
  logic        exp_mis;
  logic        mem_pend;
  int          mem_cnt;
  logic [31:0] mem_addr;
  int          gnt_pct, ready_pct, lat_fix, lat_max;
  logic [31:0] cons_q[$];
  logic        last_gnt;
  logic [31:0] last_addr;

  instr_fetch #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_gnt_i    (gnt),
    .imem_rvalid_i (rvalid),
    .imem_rdata_i  (rdata),
    .instr_valid_o (valid),
    .instr_ready_i (ready),
    .instr_o       (instr),
    .pc_o          (pc_out),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .misalign_o    (misalign)
  );

  always #5 clk = ~clk;

  // Memory contents: a distinct word per address
  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cons_at(input int i);
    if (i < cons_q.size()) return cons_q[i];
    return 32'hxxxx_xxxx;
  endfunction

  // Choose this cycle's inputs: memory replies, random grant and ready
  task automatic prep();
    rvalid      = mem_pend && (mem_cnt == 0);
    rdata       = rvalid ? memf(mem_addr) : $urandom;
    gnt         = imem_req && !mem_pend && (int'($urandom_range(0, 99)) < gnt_pct);
    ready       = (int'($urandom_range(0, 99)) < ready_pct);
    redirect    = 1'b0;
    redirect_pc = $urandom;
  endtask

  // Check against the program-order model, then advance one clock
  task automatic commit();
    last_gnt = 1'b0;
    if (!rst) begin
      if (imem_req && gnt) begin
        last_gnt  = 1'b1;
        last_addr = imem_addr;
        if (!redirect) chk("req_addr", imem_addr, exp_pc);
      end
      if (valid) begin
        chk("valid_pc", pc_out, exp_pc);
        chk("valid_instr", instr, memf(exp_pc));
      end
      if (valid && ready && !redirect) begin
        cons_q.push_back(pc_out);
        exp_pc = exp_pc + 32'd4;
      end
      if (redirect) begin
        exp_pc  = redirect_pc & ~32'h3;
        exp_mis = |redirect_pc[1:0];
      end else begin
        exp_mis = 1'b0;
      end
    end else begin
      exp_mis = 1'b0;
    end
    if (rvalid) mem_pend = 1'b0;
    else if (mem_pend) mem_cnt--;
    if (gnt) begin
      mem_pend = 1'b1;
      mem_addr = imem_addr;
      mem_cnt  = ((lat_fix > 0) ? lat_fix : int'($urandom_range(1, lat_max))) - 1;
    end
    @(posedge clk);
    #1;
    chk("misalign", {31'b0, misalign}, {31'b0, exp_mis});
  endtask

  initial begin
    logic [31:0] hold_i, hold_p, hold_a;
    logic        hit, stray;
    int          n0;

    exp_pc = RESET_PC; exp_mis = 1'b0; mem_pend = 1'b0; mem_cnt = 0; mem_addr = 32'h0;
    gnt_pct = 100; ready_pct = 100; lat_fix = 1; lat_max = 4;
    last_gnt = 1'b0; last_addr = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'b0, valid}, 32'h0);
    chk("rst_instr", instr, NOP);
    chk("rst_pc", pc_out, RESET_PC);
    chk("rst_misalign", {31'b0, misalign}, 32'h0);
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    rst = 1'b0;

    // Sequential fetch with one-cycle memory latency
    for (int i = 0; i < 40 && cons_q.size() < 3; i++) begin prep(); commit(); end
    chk("t1_count", 32'(cons_q.size()), 32'd3);
    for (int i = 0; i < 3; i++) chk("t1_pc", cons_at(i), 32'(i * 4));

    // Decode stalls for five cycles
    ready_pct = 0;
    for (int i = 0; i < 20; i++) begin
      if (valid) break;
      prep(); commit();
    end
    chk("t2_valid", {31'b0, valid}, 32'h1);
    hold_i = instr; hold_p = pc_out; hold_a = imem_addr;
    for (int i = 0; i < 5; i++) begin
      prep(); commit();
      chk("t2_hold_valid", {31'b0, valid}, 32'h1);
      chk("t2_hold_instr", instr, hold_i);
      chk("t2_hold_pc", pc_out, hold_p);
      chk("t2_hold_req", {31'b0, imem_req}, 32'h0);
      chk("t2_hold_addr", imem_addr, hold_a);
    end
    ready_pct = 100;

    // Redirect while waiting for read data that arrives two cycles later
    lat_fix = 3;
    for (int i = 0; i < 20; i++) begin prep(); commit(); if (last_gnt) break; end
    chk("t3_gnt", {31'b0, last_gnt}, 32'h1);
    prep(); redirect = 1'b1; redirect_pc = 32'h100; commit();
    hit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      prep();
      chk("t3_no_valid", {31'b0, valid}, 32'h0);
      commit();
      if (last_gnt) begin hit = 1'b1; break; end
    end
    chk("t3_hit", {31'b0, hit}, 32'h1);
    chk("t3_addr", last_addr, 32'h100);

    // Misaligned redirect coinciding with a grant
    lat_fix = 1;
    hit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      prep();
      if (imem_req && !mem_pend) begin
        gnt = 1'b1; redirect = 1'b1; redirect_pc = 32'h202;
        commit();
        hit = 1'b1;
        break;
      end
      commit();
    end
    chk("t4_hit", {31'b0, hit}, 32'h1);
    chk("t4_misalign_set", {31'b0, misalign}, 32'h1);
    prep(); commit();
    chk("t4_misalign_clear", {31'b0, misalign}, 32'h0);
    for (int i = 0; i < 20; i++) begin prep(); commit(); if (last_gnt) break; end
    chk("t4_addr", last_addr, 32'h200);

    // Address wrap at the top of the address space
    for (int i = 0; i < 20; i++) begin
      prep();
      if (imem_req) begin
        gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        commit();
        break;
      end
      commit();
    end
    n0 = cons_q.size();
    for (int i = 0; i < 30 && cons_q.size() <= n0; i++) begin prep(); commit(); end
    chk("t5_cons", cons_at(n0), 32'hFFFF_FFFC);
    for (int i = 0; i < 20; i++) begin prep(); commit(); if (last_gnt) break; end
    chk("t5_addr", last_addr, 32'h0000_0000);

    // Asynchronous reset while a response is outstanding
    lat_fix = 4;
    for (int i = 0; i < 20; i++) begin prep(); commit(); if (last_gnt) break; end
    chk("t6_gnt", {31'b0, last_gnt}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_valid", {31'b0, valid}, 32'h0);
    chk("t6_rst_instr", instr, NOP);
    chk("t6_rst_req", {31'b0, imem_req}, 32'h0);
    chk("t6_rst_pc", pc_out, RESET_PC);
    exp_pc = RESET_PC;
    prep(); commit();
    rst = 1'b0;
    stray = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      prep();
      if (rvalid) stray = 1'b1;
      chk("t6_valid", {31'b0, valid}, 32'h0);
      chk("t6_instr", instr, NOP);
      commit();
      if (last_gnt) begin hit = 1'b1; break; end
    end
    chk("t6_stray", {31'b0, stray}, 32'h1);
    chk("t6_hit", {31'b0, hit}, 32'h1);
    chk("t6_addr", last_addr, RESET_PC);

    // Random grants, latencies, stalls and redirects
    lat_fix = 0; gnt_pct = 60; ready_pct = 70;
    n0 = cons_q.size();
    for (int i = 0; i < 3000; i++) begin
      prep();
      if ($urandom_range(0, 99) < 4) begin
        redirect    = 1'b1;
        redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
      end
      commit();
    end
    chk("rand_progress", {31'b0, (cons_q.size() - n0) > 100}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
